// File: rtl/exec_pkg.sv
// Shared definitions for the multi-cycle execute core: op codes, FSM states
// and the immediate sign-extension helper.
package exec_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_LAST = OP_SRA;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Sign-extends the low imm_w bits of imm to 64 bits; callers truncate to WIDTH.
  function automatic logic [63:0] sext_imm(input logic [63:0] imm, input int unsigned imm_w);
    logic signed [63:0] t;
    t = $signed(imm << (64 - imm_w));
    return $unsigned(t >>> (64 - imm_w));
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file with two combinational read ports and one synchronous write port.
// Entry 0 always reads as zero and ignores writes.
module reg_file #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [WIDTH-1:0]  rs1_data,
  output logic [WIDTH-1:0]  rs2_data,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data
);

  logic [WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/alu_exec_core.sv
// Multi-cycle integer execute core: accept, read operands, execute, write back,
// then hold the response until the consumer takes it.
module alu_exec_core
  import exec_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int IMM_W    = 12,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic              in_use_imm,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [IMM_W-1:0]  in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_err,
  output logic [7:0]        led
);

  localparam int SHW = $clog2(WIDTH);

  state_t            state;
  logic [3:0]        op;
  logic              use_imm;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [IMM_W-1:0]  imm;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic [WIDTH-1:0]  res;
  logic              err;
  logic [WIDTH-1:0]  rs1_data;
  logic [WIDTH-1:0]  rs2_data;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_err;
  logic [SHW-1:0]    shamt;
  logic              wr_en;

  assign in_ready = (state == ST_IDLE) && !reset;
  assign wr_en    = (state == ST_WRITE) && !err && !reset;

  reg_file #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) u_reg_file (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wr_en    (wr_en),
    .wr_addr  (rd),
    .wr_data  (res)
  );

  assign shamt = opb[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_SLT:  alu_res = WIDTH'($signed(opa) < $signed(opb));
      OP_SLTU: alu_res = WIDTH'(opa < opb);
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SLL:  alu_res = opa << shamt;
      OP_SRL:  alu_res = opa >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(opa) >>> shamt);
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op        <= '0;
      use_imm   <= 1'b0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      imm       <= '0;
      opa       <= '0;
      opb       <= '0;
      res       <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
      out_err   <= 1'b0;
      led       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op      <= in_op;
            use_imm <= in_use_imm;
            rd      <= in_rd;
            rs1     <= in_rs1;
            rs2     <= in_rs2;
            imm     <= in_imm;
            state   <= ST_READ;
          end
        end
        ST_READ: begin
          opa   <= rs1_data;
          opb   <= use_imm ? WIDTH'(sext_imm(64'(imm), IMM_W)) : rs2_data;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          res   <= alu_res;
          err   <= alu_err;
          state <= ST_WRITE;
        end
        // Register file commits on this same edge via wr_en.
        ST_WRITE: begin
          out_data  <= err ? '0 : res;
          out_rd    <= rd;
          out_err   <= err;
          out_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready) begin
            if (!out_err) led <= 8'(out_data);
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_core.sv
// Directed bench for alu_exec_core: a reference model of the architectural
// registers predicts every response; directed vectors pin the model with literals.
module tb_alu_exec_core;

  localparam int WIDTH    = 32;
  localparam int NUM_REGS = 32;
  localparam int IMM_W    = 12;
  localparam int REG_AW   = 5;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic              in_use_imm;
  logic [REG_AW-1:0] in_rd;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [IMM_W-1:0]  in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [REG_AW-1:0] out_rd;
  logic              out_err;
  logic [7:0]        led;

  alu_exec_core #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .IMM_W(IMM_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_use_imm (in_use_imm),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_rd     (out_rd),
    .out_err    (out_err),
    .led        (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] mreg [32];
  logic [7:0]  led_m;
  bit          busy;
  bit          started;
  int          cyc;
  int          acc_cyc;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result of one instruction, from the instruction-set rules.
  function automatic resp_t model(input logic [3:0] op, input bit use_imm, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    logic [31:0] a, b;
    resp_t r;
    a = mreg[rs1];
    b = use_imm ? {{20{imm[11]}}, imm} : mreg[rs2];
    r.rd = rd;
    r.err = 1'b0;
    r.data = 32'd0;
    case (op)
      4'd0: r.data = a + b;
      4'd1: r.data = a - b;
      4'd2: r.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3: r.data = (a < b) ? 32'd1 : 32'd0;
      4'd4: r.data = a & b;
      4'd5: r.data = a | b;
      4'd6: r.data = a ^ b;
      4'd7: r.data = a << b[4:0];
      4'd8: r.data = a >> b[4:0];
      4'd9: r.data = $unsigned($signed(a) >>> b[4:0]);
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  // Model update on each clock edge: reset, response handshake, accept.
  always @(posedge clk) begin
    resp_t r;
    if (reset) begin
      started = 1'b1;
      busy    = 1'b0;
      led_m   = 8'h00;
      exp_q.delete();
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    end else begin
      if (busy && out_valid && out_ready && exp_q.size() > 0) begin
        if (!exp_q[0].err) led_m = exp_q[0].data[7:0];
        void'(exp_q.pop_front());
        busy = 1'b0;
      end
      if (in_valid && in_ready) begin
        r = model(in_op, in_use_imm, in_rd, in_rs1, in_rs2, in_imm);
        exp_q.push_back(r);
        if (!r.err && in_rd != 5'd0) mreg[in_rd] = r.data;
        busy    = 1'b1;
        acc_cyc = cyc;
      end
    end
    cyc++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("mon_in_ready", in_ready, !busy && !reset);
      chk("mon_out_valid", out_valid, busy && (cyc >= acc_cyc + 4));
      chk("mon_led", led, led_m);
      if (out_valid && exp_q.size() > 0) begin
        chk("mon_out_data", out_data, exp_q[0].data);
        chk("mon_out_rd", out_rd, exp_q[0].rd);
        chk("mon_out_err", out_err, exp_q[0].err);
      end
    end
  end

  task automatic send(input logic [3:0] op, input bit use_imm, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    bit ok;
    ok = 1'b0;
    in_op = op; in_use_imm = use_imm; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    chk("accept", ok, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name, input logic [31:0] ed, input logic [4:0] erd, input bit eerr);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk({name, "_latency"}, n, 4);
    chk({name, "_data"}, out_data, ed);
    chk({name, "_rd"}, out_rd, erd);
    chk({name, "_err"}, out_err, eerr);
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_use_imm = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    n_checks = 0; n_fail = 0; cyc = 0; acc_cyc = 0; busy = 1'b0; started = 1'b0; led_m = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_led", led, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    send(4'd0, 1, 5'd1, 5'd0, 5'd0, 12'd5);     wait_resp("addi_x1", 32'd5, 5'd1, 0);
    chk("led_after_addi", led, 8'h05);
    send(4'd0, 1, 5'd2, 5'd0, 5'd0, 12'hFFF);   wait_resp("addi_neg1", 32'hFFFF_FFFF, 5'd2, 0);
    send(4'd2, 0, 5'd3, 5'd2, 5'd1, 12'd0);     wait_resp("slt", 32'd1, 5'd3, 0);
    send(4'd3, 0, 5'd4, 5'd2, 5'd1, 12'd0);     wait_resp("sltu", 32'd0, 5'd4, 0);
    send(4'd0, 1, 5'd5, 5'd0, 5'd0, 12'h080);   wait_resp("addi_80", 32'h80, 5'd5, 0);
    send(4'd9, 1, 5'd6, 5'd5, 5'd0, 12'd31);    wait_resp("sra_31", 32'd0, 5'd6, 0);
    send(4'd8, 1, 5'd7, 5'd5, 5'd0, 12'd4);     wait_resp("srl_4", 32'h8, 5'd7, 0);
    chk("led_after_srl", led, 8'h08);
    send(4'd0, 1, 5'd11, 5'd0, 5'd0, 12'h800);  wait_resp("addi_min", 32'hFFFF_F800, 5'd11, 0);
    send(4'd9, 1, 5'd12, 5'd11, 5'd0, 12'd4);   wait_resp("sra_neg", 32'hFFFF_FF80, 5'd12, 0);
    send(4'd8, 1, 5'd13, 5'd11, 5'd0, 12'd4);   wait_resp("srl_neg", 32'h0FFF_FF80, 5'd13, 0);
    send(4'd1, 0, 5'd14, 5'd1, 5'd2, 12'd0);    wait_resp("sub", 32'd6, 5'd14, 0);
    send(4'd4, 0, 5'd15, 5'd2, 5'd5, 12'd0);    wait_resp("and", 32'h80, 5'd15, 0);
    send(4'd5, 0, 5'd16, 5'd1, 5'd5, 12'd0);    wait_resp("or", 32'h85, 5'd16, 0);
    send(4'd6, 0, 5'd17, 5'd2, 5'd1, 12'd0);    wait_resp("xor", 32'hFFFF_FFFA, 5'd17, 0);
    send(4'd7, 1, 5'd0, 5'd1, 5'd0, 12'd3);     wait_resp("sll_x0", 32'h28, 5'd0, 0);
    send(4'd0, 0, 5'd18, 5'd0, 5'd1, 12'd0);    wait_resp("x0_still_zero", 32'd5, 5'd18, 0);

    send(4'd12, 1, 5'd1, 5'd1, 5'd0, 12'd1);    wait_resp("illegal", 32'd0, 5'd1, 1);
    chk("led_after_illegal", led, 8'h05);
    send(4'd0, 0, 5'd8, 5'd1, 5'd0, 12'd0);     wait_resp("x1_unchanged", 32'd5, 5'd8, 0);

    // Back-pressure: response held while a new instruction is offered.
    out_ready = 1'b0;
    send(4'd0, 1, 5'd19, 5'd0, 5'd0, 12'h123);  wait_resp("hold", 32'h123, 5'd19, 0);
    in_op = 4'd0; in_use_imm = 1'b1; in_rd = 5'd20; in_rs1 = 5'd0; in_imm = 12'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_data", out_data, 32'h123);
      chk("hold_out_rd", out_rd, 5'd19);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    chk("release_led", led, 8'h23);
    @(posedge clk); #1;

    // Reset while the instruction sits in EXEC.
    send(4'd0, 1, 5'd9, 5'd0, 5'd0, 12'd7);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_data", out_data, 0);
    chk("rst2_out_rd", out_rd, 0);
    chk("rst2_out_err", out_err, 0);
    chk("rst2_led", led, 0);
    chk("rst2_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(4'd0, 0, 5'd10, 5'd9, 5'd0, 12'd0);    wait_resp("x9_not_written", 32'd0, 5'd10, 0);
    chk("led_after_rst", led, 8'h00);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_core.md
Name: alu_exec_core

Overview:
- Parametrised multi-cycle integer execute core.
- Accepts one decoded register/immediate ALU instruction at a time over a valid/ready handshake, then reads two operands from an internal register file.
- Computes one of ten ALU ops, writes the result back, and presents the result on a valid/ready response channel.
- Successor to the fixed 3-state, 3-op, 32-register datapath. Adds: parametrised width and register count, sign-extended immediates, shifts and logic ops, illegal-op reporting, and back-pressure on both sides.

Parameters:
- WIDTH, 32, datapath and register width. Legal values: 8 to 64, power of two.
- NUM_REGS, 32, register count. Power of two, 2 to 32. REG_AW = $clog2(NUM_REGS).
- IMM_W, 12, immediate width. Must satisfy IMM_W <= WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  core can accept an instruction
- in_op  in  4  ALU op code (exec_pkg)
- in_use_imm  in  1  1: second operand is the sign-extended immediate; 0: second operand is rs2
- in_rd  in  REG_AW  destination register
- in_rs1  in  REG_AW  source register 1
- in_rs2  in  REG_AW  source register 2
- in_imm  in  IMM_W  immediate
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result value
- out_rd  out  REG_AW  destination register of this result
- out_err  out  1  illegal op; no write-back occurred
- led  out  8  low byte of the last accepted result, zero-extended if WIDTH < 8

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE; all registers cleared to 0.
  - out_valid=0, out_data=0, out_rd=0, out_err=0, led=0.
  - Any in-flight instruction is dropped, with no write-back.
  - in_ready=0 while reset is high.
- States: IDLE, READ, EXEC, WRITE, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch op/use_imm/rd/rs1/rs2/imm, then go to READ.
- READ:
  - Combinational register-file reads of rs1 and rs2.
  - Latch opA=R[rs1]. Latch opB = use_imm ? sext(imm) : R[rs2].
  - Go to EXEC.
- EXEC:
  - Latch res = f(op, opA, opB) and latch err = op undefined.
  - Go to WRITE.
- WRITE:
  - If !err and rd!=0, write R[rd]=res on this edge.
  - Load out_data=res (0 if err), out_rd, out_err.
  - Go to RESP.
- RESP:
  - out_valid=1.
  - When out_ready=1: update led from out_data (unless err), clear out_valid, go to IDLE.
  - Otherwise hold all out_* stable indefinitely.
- Latency: accept edge E0 -> out_valid high after E3. Minimum issue interval is 5 cycles when out_ready is held at 1.
- in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored.
- Ops (exec_pkg), all computed modulo 2^WIDTH:
  - ADD=0, SUB=1
  - SLT=2 (signed compare, result 1 or 0), SLTU=3 (unsigned compare, result 1 or 0)
  - AND=4, OR=5, XOR=6
  - SLL=7, SRL=8, SRA=9: shift amount is opB[REG_SHW-1:0], with REG_SHW=$clog2(WIDTH)
  - Codes 10 to 15 are illegal -> err=1.
- R[0] is hard-wired 0. Writes to it are discarded, but the response still carries the computed result.
- Write-back completes before the core returns to IDLE, so a dependent next instruction always reads the updated value. No forwarding is needed.
- Reset asserted in any state overrides every transition.

Decomposition:
- Package exec_pkg holds:
  - op code localparams (OP_ADD … OP_SRA, OP_LAST=9);
  - state localparams (ST_IDLE … ST_RESP);
  - function sext_imm.
- Sub-module reg_file #(WIDTH, NUM_REGS):
  - two combinational read ports and one synchronous write port;
  - synchronous reset clears all entries;
  - R[0] reads 0.
- ALU stays a combinational case block inside alu_exec_core.

Test Plan:
- Reset, then issue ADDI rd=1, rs1=0, imm=5 with out_ready=1 -> out_valid rises exactly after the 3rd edge following accept; out_data=5, out_rd=1, led=0x05.
- Issue ADDI x2=x0+(-1) (imm=0xFFF), then SLT x3=x2<x1, then SLTU x4=x2<x1 -> out_data 0xFFFFFFFF, 1, 0.
- Issue ADDI x5=x0+0x80, then SRA x6=x5 by 31 (x2 at WIDTH=8 build), then SRL x7=x5 by 4 -> shifts correct. At WIDTH=8: SRA 0x80>>>7 gives 0xFF, and SRL gives 0x08.
- Issue op=12 with rd=1 -> out_err=1, out_data=0, R[1] unchanged (confirmed with a follow-up ADD x8=x1+x0); led unchanged.
- Hold out_ready=0 for 10 cycles in RESP while in_valid=1 -> out_* stable, in_ready=0, no second accept; release -> one handshake, then in_ready=1.
- Assert reset during EXEC of ADDI x9=x0+7 -> no write; following ADD x10=x9+x0 returns 0; all outputs 0 the cycle after reset.
